me_unit: RTL and testbench



---
 rtl/me_unit_if.sv | 33 +++
 rtl/me_unit.sv | 121 ++++++++++++
 tb/tb_me_unit.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/me_unit_if.sv
// Handshake and bus bundle between the ME stage and its neighbours
// (EX bundle in, WB bundle out, data SRAM response, flush, hazard info).
interface me_unit_if;
   logic         EX_to_ME_Valid;
   logic [129:0] EX_to_ME_Bus;
   logic         ME_Allow_in;
   logic         WB_Allow_in;
   logic         ME_to_WB_Valid;
   logic [124:0] ME_to_WB_Bus;
   logic         data_sram_data_ok;
   logic [31:0]  data_sram_rdata;
   logic         flush;
   logic [4:0]   ME_dest;
   logic [31:0]  ME_Forward_Res;
   logic         ME_load_pending;
   logic         ME_excp_flag;

   // Surrounding pipeline: drives the EX bundle, WB readiness, SRAM response, flush
   modport master (
      output EX_to_ME_Valid, EX_to_ME_Bus, WB_Allow_in,
             data_sram_data_ok, data_sram_rdata, flush,
      input  ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus,
             ME_dest, ME_Forward_Res, ME_load_pending, ME_excp_flag
   );

   // ME stage itself
   modport slave (
      input  EX_to_ME_Valid, EX_to_ME_Bus, WB_Allow_in,
             data_sram_data_ok, data_sram_rdata, flush,
      output ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus,
             ME_dest, ME_Forward_Res, ME_load_pending, ME_excp_flag
   );
endinterface

// File: rtl/me_unit.sv
// ME pipeline stage: holds the EX bundle, collects the data SRAM response,
// extracts load data and hands the finished bundle to WB. Responses owed to
// flushed instructions are dropped via the discard flag.
module me_unit (
   input  logic      clk,
   input  logic      reset,
   me_unit_if.slave  io
);
   logic         me_valid;
   logic [129:0] bundle;
   logic         data_have;
   logic [31:0]  data_buf;
   logic         discard;

   // Bundle fields (MSB first)
   logic [92:0]  pass_fields;   // excp_en .. dest, forwarded to WB unchanged
   logic         excp_en;
   logic         inst_ertn;
   logic         gr_we;
   logic [4:0]   dest;
   logic [31:0]  alu_result;
   logic         res_from_mem;
   logic [2:0]   load_op;
   logic         req_issued;

   assign pass_fields  = bundle[129:37];
   assign excp_en      = bundle[129];
   assign inst_ertn    = bundle[75];
   assign gr_we        = bundle[42];
   assign dest         = bundle[41:37];
   assign alu_result   = bundle[36:5];
   assign res_from_mem = bundle[4];
   assign load_op      = bundle[3:1];
   assign req_issued   = bundle[0];

   logic        in_wait;
   logic        resp_live;
   logic        ready_go;
   logic        allow_in;
   logic        accept;
   logic [31:0] cur_data;
   logic [7:0]  sel_b;
   logic [15:0] sel_h;
   logic [31:0] extracted;
   logic [31:0] final_result;

   // Handshake: a response is usable in the cycle it arrives unless it is owed to a flushed instruction
   always_comb begin
      in_wait   = me_valid & req_issued & ~data_have;
      resp_live = io.data_sram_data_ok & ~discard;
      ready_go  = ~req_issued | data_have | resp_live;
      allow_in  = ~me_valid | (ready_go & io.WB_Allow_in);
      accept    = io.EX_to_ME_Valid & allow_in & ~io.flush;
   end

   // Load data selection and extension
   always_comb begin
      cur_data = data_have ? data_buf : io.data_sram_rdata;
      sel_b    = cur_data[7:0];
      case (alu_result[1:0])
         2'd0:    sel_b = cur_data[7:0];
         2'd1:    sel_b = cur_data[15:8];
         2'd2:    sel_b = cur_data[23:16];
         default: sel_b = cur_data[31:24];
      endcase
      sel_h = alu_result[1] ? cur_data[31:16] : cur_data[15:0];
      case (load_op)
         3'b000:  extracted = {{24{sel_b[7]}}, sel_b};
         3'b100:  extracted = {24'd0, sel_b};
         3'b001:  extracted = {{16{sel_h[15]}}, sel_h};
         3'b101:  extracted = {16'd0, sel_h};
         default: extracted = cur_data;
      endcase
      final_result = res_from_mem ? extracted : alu_result;
   end

   // Outputs to WB and hazard/forwarding information for earlier stages
   always_comb begin
      io.ME_Allow_in     = allow_in;
      io.ME_to_WB_Valid  = me_valid & ready_go & ~io.flush;
      io.ME_to_WB_Bus    = {pass_fields, final_result};
      io.ME_dest         = dest & {5{me_valid & gr_we}};
      io.ME_Forward_Res  = final_result;
      io.ME_load_pending = me_valid & res_from_mem & ~ready_go;
      io.ME_excp_flag    = me_valid & (excp_en | inst_ertn);
   end

   // Stage state: valid bit, held bundle, response buffer and owed-response flag
   always_ff @(posedge clk) begin
      if (reset) begin
         me_valid  <= 1'b0;
         bundle    <= '0;
         data_have <= 1'b0;
         data_buf  <= '0;
         discard   <= 1'b0;
      end else begin
         if (io.flush)
            me_valid <= 1'b0;
         else if (allow_in)
            me_valid <= io.EX_to_ME_Valid;

         if (accept)
            bundle <= io.EX_to_ME_Bus;

         if (accept)
            data_have <= 1'b0;
         else if (resp_live & in_wait)
            data_have <= 1'b1;

         if (resp_live & in_wait)
            data_buf <= io.data_sram_rdata;

         // A response arriving with discard set is the stale one; otherwise a
         // flush of a waiting instruction leaves one response owed.
         if (io.data_sram_data_ok & discard)
            discard <= 1'b0;
         else if (io.flush & in_wait & ~io.data_sram_data_ok)
            discard <= 1'b1;
      end
   end
endmodule

// File: tb/tb_me_unit.sv
// Directed bench for me_unit with a scoreboard of expected WB bundles.
module tb_me_unit;
   logic clk;
   logic reset;
   me_unit_if bus_if ();

   me_unit dut (
      .clk   (clk),
      .reset (reset),
      .io    (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass;
   int n_total;
   logic [124:0] sb[$];
   logic acc;

   task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [129:0] mk(input logic ee, input logic [5:0] en,
                                       input logic [13:0] cn, input logic cwe,
                                       input logic [31:0] cwv, input logic ertn,
                                       input logic [31:0] pc, input logic gwe,
                                       input logic [4:0] dst, input logic [31:0] alu,
                                       input logic rfm, input logic [2:0] lop,
                                       input logic req);
      return {ee, en, cn, cwe, cwv, ertn, pc, gwe, dst, alu, rfm, lop, req};
   endfunction

   function automatic logic [124:0] wb_of(input logic [129:0] b, input logic [31:0] fr);
      logic [129:0] t;
      t = b;
      return {t[129:37], fr};
   endfunction

   // Sample point for the current cycle: retire scoreboard entries on WB handshake
   task automatic look();
      logic [124:0] e;
      @(negedge clk);
      if (bus_if.ME_to_WB_Valid && bus_if.WB_Allow_in) begin
         chk("sb_expected_output", sb.size() != 0, 1'b1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_wb_bus", bus_if.ME_to_WB_Bus, e);
         end
      end
      acc = bus_if.EX_to_ME_Valid && bus_if.ME_Allow_in && !bus_if.flush;
   endtask

   // Advance past the next edge; single-cycle pulses and accepted offers drop
   task automatic nxt();
      @(posedge clk);
      #1;
      if (acc) bus_if.EX_to_ME_Valid = 1'b0;
      bus_if.data_sram_data_ok = 1'b0;
      bus_if.flush = 1'b0;
   endtask

   task automatic offer(input logic [129:0] b);
      bus_if.EX_to_ME_Valid = 1'b1;
      bus_if.EX_to_ME_Bus   = b;
   endtask

   // Issued load: enters, waits w cycles, then the response arrives
   task automatic run_load(input string tag, input logic [2:0] lop, input logic [31:0] addr,
                           input int unsigned w, input logic [31:0] rdata,
                           input logic [31:0] exp_fr);
      logic [129:0] b;
      b = mk(1'b0, 6'd0, 14'd0, 1'b0, 32'd0, 1'b0, 32'h1C00_0040, 1'b1, 5'd7,
             addr, 1'b1, lop, 1'b1);
      offer(b);
      sb.push_back(wb_of(b, exp_fr));
      look();
      nxt();
      for (int unsigned i = 0; i < w; i++) begin
         look();
         chk({tag, "_pending"}, bus_if.ME_load_pending, 1'b1);
         chk({tag, "_no_valid"}, bus_if.ME_to_WB_Valid, 1'b0);
         nxt();
      end
      bus_if.data_sram_data_ok = 1'b1;
      bus_if.data_sram_rdata   = rdata;
      look();
      chk({tag, "_valid"}, bus_if.ME_to_WB_Valid, 1'b1);
      chk({tag, "_result"}, bus_if.ME_Forward_Res, exp_fr);
      chk({tag, "_pending_clr"}, bus_if.ME_load_pending, 1'b0);
      nxt();
   endtask

   typedef struct {
      logic [2:0]  lop;
      logic [31:0] addr;
      logic [31:0] exp_fr;
   } ld_vec_t;

   initial begin
      ld_vec_t vecs[$];
      logic [129:0] b;

      n_pass = 0;
      n_total = 0;
      acc = 1'b0;
      reset = 1'b1;
      bus_if.EX_to_ME_Valid = 1'b0;
      bus_if.EX_to_ME_Bus = '0;
      bus_if.WB_Allow_in = 1'b1;
      bus_if.data_sram_data_ok = 1'b0;
      bus_if.data_sram_rdata = '0;
      bus_if.flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset values
      look();
      chk("rst_valid", bus_if.ME_to_WB_Valid, 1'b0);
      chk("rst_allow", bus_if.ME_Allow_in, 1'b1);
      chk("rst_dest", bus_if.ME_dest, 5'd0);
      chk("rst_pending", bus_if.ME_load_pending, 1'b0);
      chk("rst_excp", bus_if.ME_excp_flag, 1'b0);
      chk("rst_fwd", bus_if.ME_Forward_Res, 32'd0);
      chk("rst_bus", bus_if.ME_to_WB_Bus, 125'd0);
      nxt();

      // ALU op without request: one cycle in ME
      b = mk(1'b0, 6'd0, 14'd0, 1'b0, 32'd0, 1'b0, 32'h1C00_0000, 1'b1, 5'd5,
             32'h1234_5678, 1'b0, 3'b000, 1'b0);
      offer(b);
      sb.push_back(wb_of(b, 32'h1234_5678));
      look();
      nxt();
      look();
      chk("alu_valid", bus_if.ME_to_WB_Valid, 1'b1);
      chk("alu_fwd", bus_if.ME_Forward_Res, 32'h1234_5678);
      chk("alu_dest", bus_if.ME_dest, 5'd5);
      chk("alu_allow", bus_if.ME_Allow_in, 1'b1);
      nxt();
      look();
      chk("alu_gone", bus_if.ME_to_WB_Valid, 1'b0);
      nxt();

      // Loads with response latency from the plan
      run_load("ldb", 3'b000, 32'h0000_1003, 2, 32'h80FF_0011, 32'hFFFF_FF80);
      run_load("ldhu", 3'b101, 32'h0000_1002, 1, 32'h80FF_0011, 32'h0000_80FF);

      // Extraction table, response in the first ME cycle
      vecs.push_back('{3'b000, 32'h0000_2000, 32'h0000_0011});
      vecs.push_back('{3'b000, 32'h0000_2002, 32'hFFFF_FFFF});
      vecs.push_back('{3'b100, 32'h0000_2003, 32'h0000_0080});
      vecs.push_back('{3'b001, 32'h0000_2002, 32'hFFFF_80FF});
      vecs.push_back('{3'b001, 32'h0000_2000, 32'h0000_0011});
      vecs.push_back('{3'b101, 32'h0000_2000, 32'h0000_0011});
      vecs.push_back('{3'b010, 32'h0000_2000, 32'h80FF_0011});
      vecs.push_back('{3'b011, 32'h0000_2001, 32'h80FF_0011});
      vecs.push_back('{3'b111, 32'h0000_2003, 32'h80FF_0011});
      foreach (vecs[i])
         run_load("ldtab", vecs[i].lop, vecs[i].addr, 0, 32'h80FF_0011, vecs[i].exp_fr);

      // WB stall with data present: buffered result stays stable
      bus_if.WB_Allow_in = 1'b0;
      b = mk(1'b0, 6'd0, 14'd0, 1'b0, 32'd0, 1'b0, 32'h1C00_0080, 1'b1, 5'd12,
             32'h0000_3000, 1'b1, 3'b010, 1'b1);
      offer(b);
      sb.push_back(wb_of(b, 32'hDEAD_BEEF));
      look();
      nxt();
      bus_if.data_sram_data_ok = 1'b1;
      bus_if.data_sram_rdata = 32'hDEAD_BEEF;
      for (int unsigned i = 0; i < 3; i++) begin
         look();
         chk("stall_valid", bus_if.ME_to_WB_Valid, 1'b1);
         chk("stall_allow", bus_if.ME_Allow_in, 1'b0);
         chk("stall_fwd", bus_if.ME_Forward_Res, 32'hDEAD_BEEF);
         nxt();
         bus_if.data_sram_rdata = 32'h0BAD_0BAD;
      end
      bus_if.WB_Allow_in = 1'b1;
      look();
      chk("stall_release_allow", bus_if.ME_Allow_in, 1'b1);
      nxt();
      look();
      chk("stall_gone", bus_if.ME_to_WB_Valid, 1'b0);
      nxt();

      // Flush while a load waits; its late response must be dropped
      b = mk(1'b0, 6'd0, 14'd0, 1'b0, 32'd0, 1'b0, 32'h1C00_00C0, 1'b1, 5'd9,
             32'h0000_4000, 1'b1, 3'b010, 1'b1);
      offer(b);
      look();
      nxt();
      bus_if.flush = 1'b1;
      look();
      chk("flush_no_valid", bus_if.ME_to_WB_Valid, 1'b0);
      nxt();
      b = mk(1'b0, 6'd0, 14'd0, 1'b0, 32'd0, 1'b0, 32'h1C00_0100, 1'b1, 5'd10,
             32'h0000_5000, 1'b1, 3'b010, 1'b1);
      offer(b);
      sb.push_back(wb_of(b, 32'h2222_2222));
      look();
      chk("flush_empty_allow", bus_if.ME_Allow_in, 1'b1);
      nxt();
      bus_if.data_sram_data_ok = 1'b1;
      bus_if.data_sram_rdata = 32'h1111_1111;
      look();
      chk("discard_no_valid", bus_if.ME_to_WB_Valid, 1'b0);
      chk("discard_pending", bus_if.ME_load_pending, 1'b1);
      nxt();
      bus_if.data_sram_data_ok = 1'b1;
      bus_if.data_sram_rdata = 32'h2222_2222;
      look();
      chk("second_resp_valid", bus_if.ME_to_WB_Valid, 1'b1);
      chk("second_resp_fwd", bus_if.ME_Forward_Res, 32'h2222_2222);
      nxt();

      // Flush and response in the same cycle: response consumed, nothing owed
      b = mk(1'b0, 6'd0, 14'd0, 1'b0, 32'd0, 1'b0, 32'h1C00_0140, 1'b1, 5'd11,
             32'h0000_6000, 1'b1, 3'b010, 1'b1);
      offer(b);
      look();
      nxt();
      bus_if.flush = 1'b1;
      bus_if.data_sram_data_ok = 1'b1;
      bus_if.data_sram_rdata = 32'h3333_3333;
      look();
      chk("flush_ok_no_valid", bus_if.ME_to_WB_Valid, 1'b0);
      nxt();
      run_load("post_flush_ok", 3'b010, 32'h0000_7000, 1, 32'h4444_4444, 32'h4444_4444);

      // ALE bundle: exception fields passed through, bad VA as result
      b = mk(1'b1, 6'b100000, 14'h0ABC, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h1C00_0200,
             1'b0, 5'd3, 32'h0000_1002, 1'b0, 3'b010, 1'b0);
      offer(b);
      sb.push_back(wb_of(b, 32'h0000_1002));
      look();
      nxt();
      look();
      chk("ale_excp_flag", bus_if.ME_excp_flag, 1'b1);
      chk("ale_dest", bus_if.ME_dest, 5'd0);
      chk("ale_bus", bus_if.ME_to_WB_Bus,
          {1'b1, 6'b100000, 14'h0ABC, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h1C00_0200,
           1'b0, 5'd3, 32'h0000_1002});
      nxt();

      // ertn raises the exception flag too
      b = mk(1'b0, 6'd0, 14'd0, 1'b0, 32'd0, 1'b1, 32'h1C00_0240, 1'b0, 5'd0,
             32'h0000_0000, 1'b0, 3'b000, 1'b0);
      offer(b);
      sb.push_back(wb_of(b, 32'h0000_0000));
      look();
      nxt();
      look();
      chk("ertn_excp_flag", bus_if.ME_excp_flag, 1'b1);
      nxt();

      // Reset during WAIT with a response owed to a flushed load
      b = mk(1'b0, 6'd0, 14'd0, 1'b0, 32'd0, 1'b0, 32'h1C00_0300, 1'b1, 5'd20,
             32'h0000_8000, 1'b1, 3'b010, 1'b1);
      offer(b);
      look();
      nxt();
      bus_if.flush = 1'b1;
      look();
      nxt();
      b = mk(1'b0, 6'd0, 14'd0, 1'b0, 32'd0, 1'b0, 32'h1C00_0340, 1'b1, 5'd21,
             32'h0000_9000, 1'b1, 3'b010, 1'b1);
      offer(b);
      look();
      nxt();
      reset = 1'b1;
      look();
      chk("pre_rst_pending", bus_if.ME_load_pending, 1'b1);
      nxt();
      reset = 1'b0;
      look();
      chk("midrst_valid", bus_if.ME_to_WB_Valid, 1'b0);
      chk("midrst_allow", bus_if.ME_Allow_in, 1'b1);
      chk("midrst_dest", bus_if.ME_dest, 5'd0);
      chk("midrst_pending", bus_if.ME_load_pending, 1'b0);
      chk("midrst_excp", bus_if.ME_excp_flag, 1'b0);
      chk("midrst_fwd", bus_if.ME_Forward_Res, 32'd0);
      chk("midrst_bus", bus_if.ME_to_WB_Bus, 125'd0);
      nxt();
      run_load("post_rst", 3'b010, 32'h0000_A000, 0, 32'h5555_5555, 32'h5555_5555);

      look();
      chk("sb_drained", sb.size(), 0);
      nxt();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
